// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : state and latched-request types shared by mem_port_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rd;
    logic        wr;
  } mem_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if : imem/dmem requester ports and the unified memory port
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  // slave: the arbiter; master: requesters plus memory (testbench side)
  modport slave (
    input  imem_address, imem_read,
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  mem_rdata, mem_resp,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
    output mem_address, mem_read, mem_write, mem_wmask, mem_wdata
  );

  modport master (
    output imem_address, imem_read,
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output mem_rdata, mem_resp,
    input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
    input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : imem/dmem arbiter onto one word-wide memory port
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3   // 2**CNT_W must exceed STARVE_LIMIT
) (
  input wire               clk,
  input wire               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  mem_req_t         r_req;
  logic [CNT_W-1:0] r_starve;

  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done;

  // dmem normally wins; a starved imem takes the port once the limit is hit
  assign w_d_req   = bus.dmem_read | bus.dmem_write;
  assign w_grant_i = (r_state == IDLE) && bus.imem_read &&
                     (!w_d_req || (r_starve == c_STARVE_MAX));
  assign w_grant_d = (r_state == IDLE) && w_d_req && !w_grant_i;
  assign w_done    = (r_state != IDLE) && bus.mem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_state_nxt = SERVE_I;
        end else if (w_grant_d) begin
          w_state_nxt = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req    <= '0;
      r_starve <= '0;
    end else if (w_grant_i) begin
      r_req    <= '{addr: bus.imem_address, wdata: '0, wmask: '0, rd: 1'b1, wr: 1'b0};
      r_starve <= '0;
    end else if (w_grant_d) begin
      // a simultaneous read+write is served as the write
      r_req.addr  <= bus.dmem_address;
      r_req.wdata <= bus.dmem_write ? bus.dmem_wdata : '0;
      r_req.wmask <= bus.dmem_write ? bus.dmem_wmask : 4'b0000;
      r_req.rd    <= bus.dmem_read & ~bus.dmem_write;
      r_req.wr    <= bus.dmem_write;
      if (!bus.imem_read) begin
        r_starve <= '0;
      end else if (r_starve != c_STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
    end else if (w_done) begin
      r_req.rd <= 1'b0;
      r_req.wr <= 1'b0;
    end
  end

  always_comb begin
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = '0;
    case (r_state)
      SERVE_I: begin
        if (bus.mem_resp) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = bus.mem_rdata;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_address = word_align(r_req.addr);
  assign bus.mem_read    = r_req.rd;
  assign bus.mem_write   = r_req.wr;
  assign bus.mem_wmask   = r_req.wmask;
  assign bus.mem_wdata   = r_req.wdata;

  always_ff @(posedge clk) begin
    if (!rst && w_grant_d) begin
      assert (!(bus.dmem_read && bus.dmem_write))
        else $warning("mem_port_arbiter: dmem read and write both set, serving the write");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + random bench with a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TMO          = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mem_img [16];
  logic [31:0] ref_img [16];
  bit  mem_auto;
  int  mem_lat_fixed;
  bit  inject_resp;
  bit  mem_busy;
  int  mem_cnt;
  int  mem_lat;

  bit          i_pend, d_pend, d_rd, d_wr, prev_strobe;
  logic [31:0] i_addr, d_addr, d_wdata, d_last_rdata;
  logic [3:0]  d_wmask;
  int          i_req_cyc, d_req_cyc, i_resp_cyc, d_resp_cyc, i_resp_cnt, d_resp_cnt;
  int          streak;
  byte         grant_log [$];
  int          grant_cyc [$];

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: responds L cycles after it first sees a strobe; optional one-shot stray resp
  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    mem_busy = 0; mem_cnt = 0; mem_lat = 1;
    for (int i = 0; i < 16; i++) mem_img[i] = init_word(i);
    forever begin
      @(posedge clk); #1;
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      if (inject_resp) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end else if (!mem_auto || !(bus.mem_read | bus.mem_write)) begin
        mem_busy = 0;
      end else if (!mem_busy) begin
        mem_busy = 1;
        mem_cnt  = 0;
        mem_lat  = (mem_lat_fixed > 0) ? mem_lat_fixed : int'($urandom_range(1, 3));
      end else begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          if (bus.mem_write)
            mem_img[bus.mem_address[5:2]] = merge(mem_img[bus.mem_address[5:2]],
                                                  bus.mem_wdata, bus.mem_wmask);
          else
            bus.mem_rdata = mem_img[bus.mem_address[5:2]];
          bus.mem_resp = 1'b1;
          mem_busy = 0;
        end
      end
    end
  end

  task automatic issue_i(input logic [31:0] a);
    i_addr = a; i_pend = 1; i_req_cyc = cyc;
    bus.imem_address = a; bus.imem_read = 1'b1;
  endtask

  task automatic issue_d(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] wd);
    d_rd = rd; d_wr = wr; d_addr = a; d_wmask = m; d_wdata = wd;
    d_pend = 1; d_req_cyc = cyc;
    bus.dmem_address = a; bus.dmem_read = rd; bus.dmem_write = wr;
    bus.dmem_wmask = m; bus.dmem_wdata = wd;
  endtask

  // A new strobe means a grant decided on the requests present before this edge
  task automatic check_grant();
    bit exp_d;
    chk32("grant_has_request", 32'(i_pend | d_pend), 1);
    exp_d = d_pend && !(i_pend && streak == STARVE_LIMIT);
    if (exp_d) begin
      chk32("grant_d_addr",  bus.mem_address, {d_addr[31:2], 2'b00});
      chk32("grant_d_write", 32'(bus.mem_write), 32'(d_wr));
      chk32("grant_d_read",  32'(bus.mem_read), 32'(d_rd & ~d_wr));
      chk32("grant_d_wmask", 32'(bus.mem_wmask), d_wr ? 32'(d_wmask) : 32'd0);
      if (d_wr) chk32("grant_d_wdata", bus.mem_wdata, d_wdata);
      streak = i_pend ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
      grant_log.push_back("D");
    end else begin
      chk32("grant_i_addr",  bus.mem_address, {i_addr[31:2], 2'b00});
      chk32("grant_i_read",  32'(bus.mem_read), 1);
      chk32("grant_i_write", 32'(bus.mem_write), 0);
      chk32("grant_i_wmask", 32'(bus.mem_wmask), 0);
      streak = 0;
      grant_log.push_back("I");
    end
    grant_cyc.push_back(cyc);
  endtask

  task automatic step();
    logic strobe;
    @(posedge clk); #2;
    cyc++;
    strobe = bus.mem_read | bus.mem_write;
    if (!rst && strobe && !prev_strobe) check_grant();
    prev_strobe = strobe;
    if (!bus.imem_resp) chk32("imem_rdata_idle_zero", bus.imem_rdata, 0);
    if (!bus.dmem_resp) chk32("dmem_rdata_idle_zero", bus.dmem_rdata, 0);
    if (bus.imem_resp) begin
      chk32("imem_resp_expected", 32'(i_pend), 1);
      chk32("imem_rdata", bus.imem_rdata, ref_img[i_addr[5:2]]);
      i_pend = 0; bus.imem_read = 1'b0; i_resp_cyc = cyc; i_resp_cnt++;
    end
    if (bus.dmem_resp) begin
      chk32("dmem_resp_expected", 32'(d_pend), 1);
      d_last_rdata = bus.dmem_rdata;
      if (d_wr) ref_img[d_addr[5:2]] = merge(ref_img[d_addr[5:2]], d_wdata, d_wmask);
      else      chk32("dmem_rdata", bus.dmem_rdata, ref_img[d_addr[5:2]]);
      d_pend = 0; bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; d_resp_cyc = cyc; d_resp_cnt++;
    end
    if (i_pend) begin
      chk32("imem_timeout", 32'(cyc - i_req_cyc > TMO), 0);
      if (cyc - i_req_cyc > TMO) begin i_pend = 0; bus.imem_read = 1'b0; end
    end
    if (d_pend) begin
      chk32("dmem_timeout", 32'(cyc - d_req_cyc > TMO), 0);
      if (cyc - d_req_cyc > TMO) begin d_pend = 0; bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; end
    end
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((i_pend || d_pend) && n < bound) begin step(); n++; end
    chk32("wait_done_bound", 32'(i_pend | d_pend), 0);
  endtask

  initial begin
    int  gl0, ic, dc, nd, n;
    byte exp4 [7];
    exp4 = '{"D", "D", "D", "D", "I", "D", "D"};

    rst = 1'b1;
    bus.imem_address = '0; bus.imem_read = 1'b0;
    bus.dmem_address = '0; bus.dmem_read = 1'b0; bus.dmem_write = 1'b0;
    bus.dmem_wmask = '0; bus.dmem_wdata = '0;
    mem_auto = 1; mem_lat_fixed = 0; inject_resp = 0;
    i_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0; prev_strobe = 0; streak = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; d_last_rdata = '0;
    i_req_cyc = 0; d_req_cyc = 0; i_resp_cyc = 0; d_resp_cyc = 0; i_resp_cnt = 0; d_resp_cnt = 0;
    for (int i = 0; i < 16; i++) ref_img[i] = init_word(i);

    step(); step();
    chk32("rst_mem_address", bus.mem_address, 0);
    chk32("rst_mem_read",    32'(bus.mem_read), 0);
    chk32("rst_mem_write",   32'(bus.mem_write), 0);
    chk32("rst_mem_wmask",   32'(bus.mem_wmask), 0);
    chk32("rst_mem_wdata",   bus.mem_wdata, 0);
    chk32("rst_imem_resp",   32'(bus.imem_resp), 0);
    chk32("rst_dmem_resp",   32'(bus.dmem_resp), 0);
    rst = 1'b0;
    step();

    // T1: imem alone, fixed memory latency of 2
    mem_lat_fixed = 2;
    issue_i(32'h4000_0004);
    wait_done(20);
    chk32("t1_latency", 32'(i_resp_cyc - i_req_cyc), 3);
    step();

    // T2: simultaneous requests
    mem_lat_fixed = 0;
    gl0 = grant_log.size(); ic = i_resp_cnt; dc = d_resp_cnt;
    issue_i(32'h4000_0000);
    issue_d(1, 0, 32'h8000_0010, 4'h0, 32'h0);
    wait_done(40);
    chk32("t2_first_d",  32'(grant_log[gl0]), 32'("D"));
    chk32("t2_second_i", 32'(grant_log[gl0 + 1]), 32'("I"));
    chk32("t2_i_once",   32'(i_resp_cnt - ic), 1);
    chk32("t2_d_once",   32'(d_resp_cnt - dc), 1);
    chk32("t2_bubble",   32'(grant_cyc[gl0 + 1] - d_resp_cyc), 2);
    step();

    // T3: byte store then readback of the merged word
    issue_d(0, 1, 32'h8000_0013, 4'b1000, 32'hAB00_0000);
    wait_done(20);
    issue_d(1, 0, 32'h8000_0010, 4'h0, 32'h0);
    wait_done(20);
    chk32("t3_readback", d_last_rdata, 32'hABDE_0004);
    step();

    // T4: imem held while dmem streams six loads
    gl0 = grant_log.size();
    issue_i(32'h4000_0008);
    issue_d(1, 0, 32'h8000_0020, 4'h0, 32'h0);
    nd = 1; n = 0;
    while ((i_pend || d_pend || nd < 6) && n < 200) begin
      step(); n++;
      if (!d_pend && nd < 6) begin
        issue_d(1, 0, 32'h8000_0020 + 32'(nd * 4), 4'h0, 32'h0);
        nd++;
      end
    end
    chk32("t4_bound", 32'(i_pend | d_pend), 0);
    chk32("t4_grant_count", 32'(grant_log.size() - gl0), 7);
    for (int k = 0; k < 7; k++)
      chk32($sformatf("t4_grant%0d", k), 32'(grant_log[gl0 + k]), 32'(exp4[k]));
    step();

    // T5: reset while serving dmem, then a stray mem_resp
    mem_auto = 0;
    issue_d(1, 0, 32'h8000_0030, 4'h0, 32'h0);
    step(); step();
    chk32("t5_strobe_before_rst", 32'(bus.mem_read), 1);
    rst = 1'b1;
    step();
    chk32("t5_mem_read_dropped",  32'(bus.mem_read), 0);
    chk32("t5_mem_write_dropped", 32'(bus.mem_write), 0);
    rst = 1'b0; streak = 0;
    d_pend = 0; bus.dmem_read = 1'b0; bus.dmem_write = 1'b0;
    inject_resp = 1;
    step();
    chk32("t5_no_dmem_resp", 32'(bus.dmem_resp), 0);
    chk32("t5_no_imem_resp", 32'(bus.imem_resp), 0);
    inject_resp = 0; mem_auto = 1;
    step();
    issue_d(1, 0, 32'h8000_0030, 4'h0, 32'h0);
    wait_done(20);
    chk32("t5_recovered", d_last_rdata, 32'hC0DE_000C);
    step();

    // T6: read and write together is served as a write
    issue_d(1, 1, 32'h8000_0004, 4'b0011, 32'h1234_5678);
    wait_done(20);
    issue_d(1, 0, 32'h8000_0004, 4'h0, 32'h0);
    wait_done(20);
    chk32("t6_readback", d_last_rdata, 32'h0000_5678);
    step();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if (!i_pend && $urandom_range(0, 3) == 0)
        issue_i(32'h4000_0000 | (32'($urandom_range(0, 15)) << 2));
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 2) == 0)
          issue_d(0, 1, 32'h8000_0000 | ($urandom & 32'h3F), 4'($urandom_range(1, 15)), $urandom);
        else
          issue_d(1, 0, 32'h8000_0000 | ($urandom & 32'h3F), 4'h0, 32'h0);
      end
      step();
    end
    wait_done(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
